ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Parametrised successor to the single-cycle execute stage.
- Keeps the single-cycle datapath (logic, shift, arithmetic, link), generalised to DATA_W.
- Adds arithmetic right shift, subtract, set-less-than and a multi-cycle radix-2 divider that writes HI/LO.
- Sits between the ID/EX and EX/MEM pipeline registers. It raises stallreq_o to the pipeline control block while a divide is in flight.

Parameters:
- DATA_W, 32, datapath width; power of two, 8..64.
- SHAMT_W, $clog2(DATA_W), shift-amount bits taken from reg1_i.
- CNT_W, $clog2(DATA_W)+1, divider iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- aluop_i  in  8  operation code (shared defines).
- alusel_i  in  3  result-class select.
- reg1_i  in  DATA_W  operand 1 / shift amount / dividend.
- reg2_i  in  DATA_W  operand 2 / shifted value / divisor.
- wd_i  in  5  destination register address.
- wreg_i  in  1  destination write enable.
- link_address_i  in  DATA_W  return address for link instructions.
- is_in_delayslot_i  in  1  delay-slot flag; passed through unused.
- annul_i  in  1  flush: abort any divide in flight.
- wd_o  out  5  destination register address.
- wreg_o  out  1  destination write enable.
- wdata_o  out  DATA_W  result.
- whilo_o  out  1  HI/LO write strobe.
- hi_o  out  DATA_W  remainder.
- lo_o  out  DATA_W  quotient.
- stallreq_o  out  1  stall request to pipeline control.
- ovf_o  out  1  signed overflow flag (feature only; 0 otherwise).

Behaviour:
- Reset: rst low asynchronously forces FSM=IDLE and clears counter and operand registers.
  - While rst is low all outputs are 0.
- Single-cycle ops are combinational, zero latency; wd_o=wd_i, wreg_o=wreg_i.
- Logic ops: OR, AND, XOR, NOR.
- Shift ops:
  - SLL/SRL shift reg2_i by reg1_i[SHAMT_W-1:0].
  - SRA replicates reg2_i[DATA_W-1].
- Arithmetic ops:
  - ADD/ADDU/ADDI/ADDIU: reg1+reg2, modulo 2^DATA_W.
  - SUB/SUBU: reg1-reg2, modulo 2^DATA_W.
  - SLT: signed compare; SLTU: unsigned compare. Result 1 or 0, zero-extended.
- alusel_i selects the result class:
  - LOGIC, SHIFT, ARITH select the matching result above.
  - JUMPB selects link_address_i.
  - Any other value gives wdata_o=0.
- Unlisted aluop within a class gives 0.
- Divider FSM states: IDLE, BYZERO, ON, END.
  - IDLE: aluop DIV/DIVU and annul_i=0 latches operands and asserts stallreq_o. Next state is BYZERO if reg2_i==0, else ON with counter=0.
  - Signed DIV latches operand magnitudes plus both sign bits.
  - ON: one restoring shift-subtract step per cycle; stallreq_o=1. After DATA_W steps go to END.
  - BYZERO: quotient=0, remainder=0; stallreq_o=1; next END.
  - END: stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder; next IDLE.
  - END cycle only: wreg_o is forced 0.
- Signed DIV fix-up: quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Latency: stall lasts DATA_W+1 cycles and the result appears in cycle DATA_W+1 after issue. Divide by zero stalls 2 cycles.
- Operand changes while stalled are ignored, because operands are latched in IDLE.
- annul_i=1 in any state: next state is IDLE, stallreq_o=0 that cycle, no whilo_o pulse.
- Most-negative dividend / -1: quotient wraps to the most-negative value, remainder 0.
- Back-to-back divides: END always returns to IDLE. A DIV that arrives in the cycle after END starts a fresh operation.

Optional Feature:
- Macro: EX_OVF_TRAP_EN.
- Defined: ADD/ADDI/SUB with signed overflow forces wreg_o=0 and ovf_o=1, combinationally.
  - Overflow condition: operand signs equal (SUB: signs differ) and the result sign differs.
  - ADDU/ADDIU/SUBU never trap.
- Undefined: ovf_o is tied 0 and all adds/subtracts write normally.

Decomposition:
- Shared defines package holds:
  - aluop codes, including the new SRA, NOR, SUB, SUBU, SLT, SLTU, DIV, DIVU;
  - alusel codes;
  - divider state encoding;
  - active-low reset level constant.
- Natural sub-module: div_seq, containing the FSM, counter and restoring datapath.
  - Ports: start, signed_div, annul, operands, ready, quotient, remainder.
  - ex_div keeps the combinational result mux.

Test Plan (DATA_W=32):
- ALU and shift sweep: SRA 0x80000000 by 4 -> 0xF8000000. SLT 0xFFFFFFFF vs 1 -> 1. SLTU with the same operands -> 0. JUMPB -> link_address_i.
- Signed divide: DIV 7 / -2 -> stallreq_o high 33 cycles; END gives lo_o=0xFFFFFFFD, hi_o=0x00000001, whilo_o=1 for one cycle.
- Unsigned divide with operand churn: DIVU 0xFFFFFFFF / 16 -> lo_o=0x0FFFFFFF, hi_o=0xF. Randomise reg1/reg2 during the stall; the result must not change.
- Divide by zero: DIV 5 / 0 -> stall 2 cycles, lo_o=hi_o=0, whilo_o=1.
- Abort: annul_i pulsed at ON cycle 10 -> stallreq_o=0 that cycle, no whilo_o. Async reset mid-divide -> all outputs 0 immediately, FSM in IDLE.
- Overflow (EX_OVF_TRAP_EN defined): ADD 0x7FFFFFFF+1 -> ovf_o=1, wreg_o=0. ADDU with the same operands -> 0x80000000 written, ovf_o=0.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared definitions for the ex_div execute stage: operation codes, result
// class selects, divider state encoding and the reset level.
package ex_div_pkg;

  localparam int unsigned ALUOP_W  = 8;
  localparam int unsigned ALUSEL_W = 3;
  localparam int unsigned REGA_W   = 5;

  // Reset is asserted when rst equals this level.
  localparam logic RST_LEVEL = 1'b0;

  // Operation codes.
  localparam logic [ALUOP_W-1:0] ALU_NOP   = 8'h00;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 8'h24;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 8'h25;
  localparam logic [ALUOP_W-1:0] ALU_XOR   = 8'h26;
  localparam logic [ALUOP_W-1:0] ALU_NOR   = 8'h27;
  localparam logic [ALUOP_W-1:0] ALU_SLL   = 8'h7C;
  localparam logic [ALUOP_W-1:0] ALU_SRL   = 8'h02;
  localparam logic [ALUOP_W-1:0] ALU_SRA   = 8'h03;
  localparam logic [ALUOP_W-1:0] ALU_ADD   = 8'h20;
  localparam logic [ALUOP_W-1:0] ALU_ADDU  = 8'h21;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 8'h22;
  localparam logic [ALUOP_W-1:0] ALU_SUBU  = 8'h23;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 8'h2A;
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = 8'h2B;
  localparam logic [ALUOP_W-1:0] ALU_ADDI  = 8'h55;
  localparam logic [ALUOP_W-1:0] ALU_ADDIU = 8'h56;
  localparam logic [ALUOP_W-1:0] ALU_DIV   = 8'h1A;
  localparam logic [ALUOP_W-1:0] ALU_DIVU  = 8'h1B;

  // Result class selects.
  localparam logic [ALUSEL_W-1:0] SEL_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] SEL_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] SEL_MOVE  = 3'b011;
  localparam logic [ALUSEL_W-1:0] SEL_ARITH = 3'b100;
  localparam logic [ALUSEL_W-1:0] SEL_JUMPB = 3'b110;

  // Divider FSM states.
  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

endpackage

// File: rtl/ex_div_div_seq.sv
// Multi-cycle radix-2 restoring divider for the ex_div execute stage.
// Operands are latched in IDLE; DATA_W shift-subtract steps follow, then a
// single END cycle presents the sign-corrected quotient and remainder.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start, signed_div     begin a divide (sampled only in IDLE), signedness
//   annul                 abort; returns to IDLE with no result
//   dividend, divisor     operands
//   busy                  stall request while the divide is in flight
//   ready                 one-cycle result strobe (END, not annulled)
//   quotient, remainder   result, valid while ready, else 0
module ex_div_div_seq
  import ex_div_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  div_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] quo_q, quo_nxt;
  logic [DATA_W-1:0] rem_q, rem_nxt;
  logic [DATA_W-1:0] dsr_q, dsr_nxt;
  logic              neg_quo_q, neg_quo_nxt;
  logic              neg_rem_q, neg_rem_nxt;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dsr_mag;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // exactly its unsigned magnitude.
  assign dvd_mag = (signed_div && dividend[DATA_W-1]) ? (~dividend + DATA_W'(1)) : dividend;
  assign dsr_mag = (signed_div && divisor[DATA_W-1])  ? (~divisor + DATA_W'(1))  : divisor;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (rst == RST_LEVEL) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      quo_q     <= quo_nxt;
      rem_q     <= rem_nxt;
      dsr_q     <= dsr_nxt;
      neg_quo_q <= neg_quo_nxt;
      neg_rem_q <= neg_rem_nxt;
    end
  end

  // Next state, restoring step and status outputs.
  always_comb begin : next_logic
    state_nxt   = state;
    cnt_nxt     = cnt;
    quo_nxt     = quo_q;
    rem_nxt     = rem_q;
    dsr_nxt     = dsr_q;
    neg_quo_nxt = neg_quo_q;
    neg_rem_nxt = neg_rem_q;
    busy        = 1'b0;
    ready       = 1'b0;
    // Quotient register doubles as the dividend shift register.
    trial       = {rem_q, quo_q[DATA_W-1]};
    diff        = trial - {1'b0, dsr_q};

    if (annul) begin
      state_nxt = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            busy        = 1'b1;
            cnt_nxt     = '0;
            quo_nxt     = dvd_mag;
            rem_nxt     = '0;
            dsr_nxt     = dsr_mag;
            neg_quo_nxt = signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_rem_nxt = signed_div & dividend[DATA_W-1];
            state_nxt   = (divisor == '0) ? DIV_BYZERO : DIV_ON;
          end
        end
        DIV_BYZERO: begin
          busy      = 1'b1;
          quo_nxt   = '0;
          rem_nxt   = '0;
          state_nxt = DIV_END;
        end
        DIV_ON: begin
          busy    = 1'b1;
          // Borrow out of the trial subtraction means restore.
          rem_nxt = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
          quo_nxt = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state_nxt = DIV_END;
          end
        end
        DIV_END: begin
          ready     = 1'b1;
          state_nxt = DIV_IDLE;
        end
        default: begin
          state_nxt = DIV_IDLE;
        end
      endcase
    end
  end

  // Sign fix-up: quotient negated on differing signs, remainder follows dividend.
  assign quotient  = ready ? (neg_quo_q ? (~quo_q + DATA_W'(1)) : quo_q) : '0;
  assign remainder = ready ? (neg_rem_q ? (~rem_q + DATA_W'(1)) : rem_q) : '0;

endmodule

// File: rtl/ex_div.sv
// Execute stage: single-cycle logic/shift/arithmetic/link datapath plus a
// multi-cycle divider writing HI/LO. Raises stallreq_o while a divide runs.
// Optional feature macro EX_OVF_TRAP_EN: signed overflow on ADD/ADDI/SUB
// suppresses the register write and raises ovf_o; otherwise ovf_o is 0.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   aluop_i, alusel_i      operation code and result class
//   reg1_i, reg2_i         operands (shift amount/dividend, value/divisor)
//   wd_i, wreg_i           destination address and write enable
//   link_address_i         return address for link instructions
//   is_in_delayslot_i      delay-slot flag (not used here)
//   annul_i                flush; aborts a divide in flight
//   wd_o, wreg_o, wdata_o  register write-back
//   whilo_o, hi_o, lo_o    HI/LO write (remainder, quotient)
//   stallreq_o             stall request to pipeline control
//   ovf_o                  signed overflow flag
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = $clog2(DATA_W),
  parameter int unsigned CNT_W   = $clog2(DATA_W) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ALUOP_W-1:0]  aluop_i,
  input  logic [ALUSEL_W-1:0] alusel_i,
  input  logic [DATA_W-1:0]   reg1_i,
  input  logic [DATA_W-1:0]   reg2_i,
  input  logic [REGA_W-1:0]   wd_i,
  input  logic                wreg_i,
  input  logic [DATA_W-1:0]   link_address_i,
  input  logic                is_in_delayslot_i,
  input  logic                annul_i,
  output logic [REGA_W-1:0]   wd_o,
  output logic                wreg_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic                whilo_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                stallreq_o,
  output logic                ovf_o
);

  logic               in_reset;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  logic_res;
  logic [DATA_W-1:0]  shift_res;
  logic [DATA_W-1:0]  arith_res;
  logic [DATA_W-1:0]  sum;
  logic [DATA_W-1:0]  dif;
  logic               lt_s;
  logic               lt_u;
  logic [DATA_W-1:0]  result;
  logic               ovf_c;
  logic               div_start;
  logic               div_signed;
  logic               div_busy;
  logic               div_ready;
  logic [DATA_W-1:0]  div_quo;
  logic [DATA_W-1:0]  div_rem;
  logic               unused_delayslot;

  assign in_reset         = (rst == RST_LEVEL);
  assign unused_delayslot = is_in_delayslot_i;
  assign shamt            = reg1_i[SHAMT_W-1:0];
  assign sum              = reg1_i + reg2_i;
  assign dif              = reg1_i - reg2_i;
  assign lt_s             = $signed(reg1_i) < $signed(reg2_i);
  assign lt_u             = reg1_i < reg2_i;
  assign div_start        = (aluop_i == ALU_DIV) || (aluop_i == ALU_DIVU);
  assign div_signed       = (aluop_i == ALU_DIV);

  // Logic class.
  always_comb begin : logic_mux
    logic_res = '0;
    case (aluop_i)
      ALU_OR:  logic_res = reg1_i | reg2_i;
      ALU_AND: logic_res = reg1_i & reg2_i;
      ALU_XOR: logic_res = reg1_i ^ reg2_i;
      ALU_NOR: logic_res = ~(reg1_i | reg2_i);
      default: logic_res = '0;
    endcase
  end

  // Shift class: value in reg2_i, amount in the low bits of reg1_i.
  always_comb begin : shift_mux
    shift_res = '0;
    case (aluop_i)
      ALU_SLL: shift_res = reg2_i << shamt;
      ALU_SRL: shift_res = reg2_i >> shamt;
      ALU_SRA: shift_res = $unsigned($signed(reg2_i) >>> shamt);
      default: shift_res = '0;
    endcase
  end

  // Arithmetic class.
  always_comb begin : arith_mux
    arith_res = '0;
    case (aluop_i)
      ALU_ADD, ALU_ADDU, ALU_ADDI, ALU_ADDIU: arith_res = sum;
      ALU_SUB, ALU_SUBU:                      arith_res = dif;
      ALU_SLT:  arith_res = {{(DATA_W-1){1'b0}}, lt_s};
      ALU_SLTU: arith_res = {{(DATA_W-1){1'b0}}, lt_u};
      default:  arith_res = '0;
    endcase
  end

  // Result class select.
  always_comb begin : result_mux
    result = '0;
    case (alusel_i)
      SEL_LOGIC: result = logic_res;
      SEL_SHIFT: result = shift_res;
      SEL_ARITH: result = arith_res;
      SEL_JUMPB: result = link_address_i;
      default:   result = '0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  // Signed overflow: same-sign add or different-sign subtract flips the sign.
  always_comb begin : ovf_detect
    ovf_c = 1'b0;
    if (alusel_i == SEL_ARITH) begin
      if ((aluop_i == ALU_ADD) || (aluop_i == ALU_ADDI)) begin
        ovf_c = (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) && (sum[DATA_W-1] != reg1_i[DATA_W-1]);
      end else if (aluop_i == ALU_SUB) begin
        ovf_c = (reg1_i[DATA_W-1] != reg2_i[DATA_W-1]) && (dif[DATA_W-1] != reg1_i[DATA_W-1]);
      end
    end
  end
`else
  assign ovf_c = 1'b0;
`endif

  ex_div_div_seq #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_div_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .signed_div (div_signed),
    .annul      (annul_i),
    .dividend   (reg1_i),
    .divisor    (reg2_i),
    .busy       (div_busy),
    .ready      (div_ready),
    .quotient   (div_quo),
    .remainder  (div_rem)
  );

  // Output stage; everything held at 0 while reset is asserted.
  always_comb begin : out_mux
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    ovf_o      = 1'b0;
    if (!in_reset) begin
      wd_o       = wd_i;
      // The divide result goes to HI/LO only, never to the register file.
      wreg_o     = wreg_i & ~ovf_c & ~div_ready;
      wdata_o    = result;
      whilo_o    = div_ready;
      hi_o       = div_rem;
      lo_o       = div_quo;
      stallreq_o = div_busy;
      ovf_o      = ovf_c;
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div (DATA_W=32): drivers push expected results
// computed by an arithmetic reference model; a negedge monitor pops and
// compares whenever the DUT presents a result.
module tb_ex_div;
  import ex_div_pkg::*;

  localparam int unsigned W = 32;
`ifdef EX_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    aluop;
  logic [2:0]    alusel;
  logic [W-1:0]  reg1, reg2, link;
  logic [4:0]    wd;
  logic          wreg, dslot, annul;
  logic [4:0]    wd_o;
  logic          wreg_o, whilo_o, stallreq_o, ovf_o;
  logic [W-1:0]  wdata_o, hi_o, lo_o;

  always #5 clk = ~clk;

  ex_div #(.DATA_W(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .aluop_i           (aluop),
    .alusel_i          (alusel),
    .reg1_i            (reg1),
    .reg2_i            (reg2),
    .wd_i              (wd),
    .wreg_i            (wreg),
    .link_address_i    (link),
    .is_in_delayslot_i (dslot),
    .annul_i           (annul),
    .wd_o              (wd_o),
    .wreg_o            (wreg_o),
    .wdata_o           (wdata_o),
    .whilo_o           (whilo_o),
    .hi_o              (hi_o),
    .lo_o              (lo_o),
    .stallreq_o        (stallreq_o),
    .ovf_o             (ovf_o)
  );

  typedef struct { logic [W-1:0] wdata; logic wreg; logic [4:0] wd; logic ovf; } alu_exp_t;
  typedef struct { logic [W-1:0] lo; logic [W-1:0] hi; } div_exp_t;

  alu_exp_t alu_q[$];
  div_exp_t div_q[$];
  int       stall_q[$];
  logic     alu_valid = 1'b0;
  int       whilo_cnt = 0;
  int       mon_run = 0;
  logic     mon_prev_whilo = 1'b0;
  int       checks = 0;
  int       passed = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference ALU written as plain arithmetic on 64-bit integers.
  function automatic logic [W-1:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                           input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] lnk);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint pw = 64'(2) ** (ua % 32);
    case (sel)
      SEL_LOGIC: case (op)
        ALU_OR:  return a | b;
        ALU_AND: return a & b;
        ALU_XOR: return a ^ b;
        ALU_NOR: return ~(a | b);
        default: return '0;
      endcase
      SEL_SHIFT: case (op)
        ALU_SLL: return W'(ub * pw);
        ALU_SRL: return W'(ub / pw);
        ALU_SRA: return (sb >= 0) ? W'(sb / pw) : W'(-((-sb + pw - 1) / pw));
        default: return '0;
      endcase
      SEL_ARITH: case (op)
        ALU_ADD, ALU_ADDU, ALU_ADDI, ALU_ADDIU: return W'(ua + ub);
        ALU_SUB, ALU_SUBU: return W'(ua - ub);
        ALU_SLT:  return (sa < sb) ? W'(1) : W'(0);
        ALU_SLTU: return (ua < ub) ? W'(1) : W'(0);
        default:  return '0;
      endcase
      SEL_JUMPB: return lnk;
      default:   return '0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [7:0] op, input logic [2:0] sel,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    if (sel != SEL_ARITH) return 1'b0;
    if ((op == ALU_ADD) || (op == ALU_ADDI)) r = sa + sb;
    else if (op == ALU_SUB) r = sa - sb;
    else return 1'b0;
    return TRAP_EN && ((r > 64'sd2147483647) || (r < -64'sd2147483648));
  endfunction

  function automatic div_exp_t ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    div_exp_t r;
    longint x, y;
    if (b == '0) begin
      r.lo = '0;
      r.hi = '0;
    end else begin
      x = sgn ? longint'($signed(a)) : longint'({32'b0, a});
      y = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      r.lo = W'(x / y);
      r.hi = W'(x % y);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic alu_op(input logic [7:0] op, input logic [2:0] sel,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] lnk);
    alu_exp_t e;
    @(posedge clk); #1;
    aluop = op; alusel = sel; reg1 = a; reg2 = b; link = lnk;
    wd = 5'($urandom); wreg = 1'($urandom);
    alu_valid = 1'b1;
    e.ovf   = ref_ovf(op, sel, a, b);
    e.wdata = ref_alu(op, sel, a, b, lnk);
    e.wreg  = wreg & ~e.ovf;
    e.wd    = wd;
    alu_q.push_back(e);
  endtask

  task automatic div_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input logic churn);
    int target;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    aluop = sgn ? ALU_DIV : ALU_DIVU; alusel = SEL_NOP;
    reg1 = a; reg2 = b; wreg = 1'b1; wd = 5'($urandom);
    div_q.push_back(ref_div(sgn, a, b));
    stall_q.push_back((b == '0) ? 2 : W + 1);
    target = whilo_cnt + 1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (whilo_cnt >= target) break;
      if (churn && n > 0) begin reg1 = $urandom; reg2 = $urandom; end
    end
    check("div_done", W'(whilo_cnt >= target), W'(1));
    aluop = ALU_NOP;
  endtask

  // Monitor: compares every presented result against the scoreboard.
  always @(negedge clk) begin
    alu_exp_t e;
    div_exp_t d;
    if (alu_valid) begin
      check("alu_pending", W'(alu_q.size() > 0), W'(1));
      if (alu_q.size() > 0) begin
        e = alu_q.pop_front();
        check("alu_wdata", wdata_o, e.wdata);
        check("alu_wreg", W'(wreg_o), W'(e.wreg));
        check("alu_wd", W'(wd_o), W'(e.wd));
        check("alu_ovf", W'(ovf_o), W'(e.ovf));
      end
    end
    if (whilo_o) begin
      whilo_cnt++;
      check("whilo_single", W'(mon_prev_whilo), W'(0));
      check("end_wreg", W'(wreg_o), W'(0));
      check("whilo_expected", W'(div_q.size() > 0), W'(1));
      if (div_q.size() > 0) begin
        d = div_q.pop_front();
        check("div_lo", lo_o, d.lo);
        check("div_hi", hi_o, d.hi);
      end
    end
    mon_prev_whilo = whilo_o;
    if (stallreq_o) mon_run++;
    else if (mon_run > 0) begin
      check("stall_expected", W'(stall_q.size() > 0), W'(1));
      if (stall_q.size() > 0) check("stall_len", W'(mon_run), W'(stall_q.pop_front()));
      mon_run = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int idx;
    logic [7:0] ops[14];
    logic [2:0] sels[14];
    logic [W-1:0] b;
    ops  = '{ALU_OR, ALU_AND, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA,
             ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_SLT, ALU_SLTU, ALU_ADDI};
    sels = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_SHIFT, SEL_SHIFT, SEL_SHIFT,
             SEL_ARITH, SEL_ARITH, SEL_ARITH, SEL_ARITH, SEL_ARITH, SEL_ARITH, SEL_ARITH};

    // Reset with live inputs: every output must read 0.
    rst = 1'b0; aluop = ALU_OR; alusel = SEL_LOGIC; reg1 = 32'hF0; reg2 = 32'h0F;
    link = 32'h1234_5678; wd = 5'd3; wreg = 1'b1; dslot = 1'b0; annul = 1'b0;
    #12;
    check("rst_wdata", wdata_o, W'(0));
    check("rst_wreg", W'(wreg_o), W'(0));
    check("rst_wd", W'(wd_o), W'(0));
    check("rst_stall", W'(stallreq_o), W'(0));
    check("rst_whilo", W'(whilo_o), W'(0));
    rst = 1'b1;

    // Directed ALU cases.
    alu_op(ALU_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000, 0);
    alu_op(ALU_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 0);
    alu_op(ALU_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 0);
    alu_op(ALU_NOP, SEL_JUMPB, 32'd5, 32'd6, 32'hBFC0_0108);
    alu_op(ALU_OR, SEL_MOVE, 32'hFF, 32'hFF00, 0);
    alu_op(8'hFF, SEL_LOGIC, 32'hFF, 32'hFF00, 0);
    alu_op(ALU_NOR, SEL_LOGIC, 32'h0F0F_0000, 32'h0000_00FF, 0);
    alu_op(ALU_ADD, SEL_ARITH, 32'h7FFF_FFFF, 32'd1, 0);
    alu_op(ALU_ADDU, SEL_ARITH, 32'h7FFF_FFFF, 32'd1, 0);
    alu_op(ALU_SUB, SEL_ARITH, 32'h8000_0000, 32'd1, 0);
    alu_op(ALU_SUBU, SEL_ARITH, 32'h8000_0000, 32'd1, 0);

    // Randomised ALU sweep, occasionally with a mismatched class.
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 13);
      alu_op(ops[idx], ($urandom_range(0, 4) == 0) ? 3'($urandom) : sels[idx],
             pick_val(), pick_val(), $urandom);
    end

    // Directed divides.
    div_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    div_op(1'b0, 32'hFFFF_FFFF, 32'd16, 1'b1);
    div_op(1'b1, 32'd5, 32'd0, 1'b0);
    div_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Annul at the tenth ON cycle: no result, stall drops that cycle.
    @(posedge clk); #1;
    aluop = ALU_DIV; reg1 = 32'd100; reg2 = 32'd3; wreg = 1'b1;
    base = whilo_cnt;
    stall_q.push_back(10);
    repeat (10) @(posedge clk);
    #1; annul = 1'b1; aluop = ALU_NOP;
    @(negedge clk); #1;
    check("annul_stall", W'(stallreq_o), W'(0));
    check("annul_whilo", W'(whilo_o), W'(0));
    @(posedge clk); #1; annul = 1'b0;
    repeat (40) @(posedge clk);
    check("annul_no_result", W'(whilo_cnt), W'(base));

    // Asynchronous reset mid-divide.
    @(posedge clk); #1;
    aluop = ALU_DIVU; reg1 = 32'd1000; reg2 = 32'd7; wreg = 1'b1; wd = 5'd9;
    base = whilo_cnt;
    stall_q.push_back(5);
    repeat (5) @(posedge clk);
    #2; rst = 1'b0; #1;
    check("mid_rst_stall", W'(stallreq_o), W'(0));
    check("mid_rst_wreg", W'(wreg_o), W'(0));
    check("mid_rst_wd", W'(wd_o), W'(0));
    check("mid_rst_lo", lo_o, W'(0));
    check("mid_rst_hi", hi_o, W'(0));
    aluop = ALU_NOP;
    repeat (2) @(posedge clk);
    #3; rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_no_result", W'(whilo_cnt), W'(base));
    check("post_rst_stall", W'(stallreq_o), W'(0));

    // Randomised back-to-back divides.
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      div_op(1'($urandom), pick_val(), b, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    check("queues_drained", W'(alu_q.size() + div_q.size() + stall_q.size()), W'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
